// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by vga_timing_gen and consumed by the pixel renderer.
// Every signal is a registered output of the generator except pix_tick.
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          pix_tick;
    logic          h_sync;
    logic          v_sync;
    logic          video_on;
    logic [CW-1:0] x_loc;
    logic [CW-1:0] y_loc;
    logic          line_start;
    logic          frame_start;

    modport master (
        output pix_tick, h_sync, v_sync, video_on, x_loc, y_loc, line_start, frame_start
    );

    modport slave (
        input pix_tick, h_sync, v_sync, video_on, x_loc, y_loc, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: clock divider, h/v counters and registered decode.
// Decoded outputs are loaded from the decode of the next (h,v) so they always match x_loc/y_loc.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CLK_DIV   = 2,
    parameter int CW        = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    vga_timing_gen_if.master  vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Window bounds are one bit wider than the counters so an edge equal to 2^CW still fits.
    localparam logic [CW:0] HA_END   = (CW+1)'(H_DISPLAY);
    localparam logic [CW:0] HS_START = (CW+1)'(H_DISPLAY + H_FRONT);
    localparam logic [CW:0] HS_END   = (CW+1)'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CW:0] VA_END   = (CW+1)'(V_DISPLAY);
    localparam logic [CW:0] VS_START = (CW+1)'(V_DISPLAY + V_FRONT);
    localparam logic [CW:0] VS_END   = (CW+1)'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DW-1:0] r_div_cnt;
    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic          r_h_sync;
    logic          r_v_sync;
    logic          r_video_on;
    logic          r_line_start;
    logic          r_frame_start;

    logic          w_div_last;
    logic          w_pix_tick;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [CW-1:0] w_h_next;
    logic [CW-1:0] w_v_next;
    logic [CW:0]   w_h_ext;
    logic [CW:0]   w_v_ext;

    assign w_div_last = (r_div_cnt == DW'(CLK_DIV - 1));
    assign w_pix_tick = en & w_div_last & ~reset;

    assign w_h_wrap = (r_h == CW'(H_TOTAL - 1));
    assign w_v_wrap = (r_v == CW'(V_TOTAL - 1));
    assign w_h_next = w_h_wrap ? '0 : r_h + CW'(1);
    assign w_v_next = w_h_wrap ? (w_v_wrap ? '0 : r_v + CW'(1)) : r_v;
    assign w_h_ext  = {1'b0, w_h_next};
    assign w_v_ext  = {1'b0, w_v_next};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt     <= '0;
            r_h           <= '0;
            r_v           <= '0;
            r_h_sync      <= ~HS_POL;
            r_v_sync      <= ~VS_POL;
            r_video_on    <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // Strobes only follow an advancing edge, so they fall after one clock regardless of en.
            r_line_start  <= w_pix_tick & w_h_wrap;
            r_frame_start <= w_pix_tick & w_h_wrap & w_v_wrap;
            if (en) begin
                r_div_cnt <= w_div_last ? '0 : r_div_cnt + DW'(1);
            end
            if (w_pix_tick) begin
                r_h        <= w_h_next;
                r_v        <= w_v_next;
                r_video_on <= (w_h_ext < HA_END) && (w_v_ext < VA_END);
                r_h_sync   <= ((w_h_ext >= HS_START) && (w_h_ext < HS_END)) ? HS_POL : ~HS_POL;
                r_v_sync   <= ((w_v_ext >= VS_START) && (w_v_ext < VS_END)) ? VS_POL : ~VS_POL;
            end
        end
    end

    assign vga.pix_tick    = w_pix_tick;
    assign vga.h_sync      = r_h_sync;
    assign vga.v_sync      = r_v_sync;
    assign vga.video_on    = r_video_on;
    assign vga.x_loc       = r_h;
    assign vga.y_loc       = r_v;
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised, self-contained VGA raster timing generator. It derives a pixel-rate tick from the system clock and runs internal horizontal and vertical counters. From those counters it produces registered sync, blanking, coordinate and line/frame strobe outputs. It sits between the clock/reset source and the pixel renderer, which takes `x_loc`/`y_loc`/`video_on` and uses `pix_tick` to qualify pixel data.

## Interface
- `H_DISPLAY`, 640: active pixels per line
- `H_FRONT`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: horizontal sync width, pixels
- `H_BACK`, 48: horizontal back porch, pixels
- `V_DISPLAY`, 480: active lines per frame
- `V_FRONT`, 10: vertical front porch, lines
- `V_SYNC`, 2: vertical sync width, lines
- `V_BACK`, 33: vertical back porch, lines
- `HS_POL`, 0: asserted level of `h_sync` (0 = active-low)
- `VS_POL`, 0: asserted level of `v_sync`
- `CLK_DIV`, 2: system clocks per pixel; must be ≥1
- `CW`, 10: counter/coordinate width; H_TOTAL and V_TOTAL must be ≤ 2^CW
- `clk` in 1: system clock; one clock domain; all state updates on the rising edge
- `reset` in 1: synchronous, active-high reset
- `en` in 1: run enable; when low, all state holds
- `pix_tick` out 1: high in the clock cycle in which the counters advance at the next edge
- `h_sync` out 1: horizontal sync, polarity set by HS_POL
- `v_sync` out 1: vertical sync, polarity set by VS_POL
- `video_on` out 1: current pixel is in the active area
- `x_loc` out CW: current horizontal count
- `y_loc` out CW: current vertical count
- `line_start` out 1: one-clock pulse when h wraps to 0
- `frame_start` out 1: one-clock pulse when (h,v) wraps to (0,0)

## Operation
- Totals:
  - H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK (default 800).
  - V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK (default 525).
- Divider `div_cnt` counts 0..CLK_DIV-1 while `en`=1 and wraps to 0.
  - `pix_tick` = `en` & (`div_cnt` == CLK_DIV-1) & ~`reset`.
  - With CLK_DIV=1, `pix_tick` = `en` & ~`reset`.
- On an edge where `pix_tick`=1:
  - h ← h+1; at h = H_TOTAL-1, h ← 0 and v advances.
  - v ← v+1; at v = V_TOTAL-1, v ← 0.
- Decoded outputs are registered. On each advancing edge they load the decode of the new (h,v), so they are always consistent with `x_loc`/`y_loc`.
  - `video_on` = h < H_DISPLAY && v < V_DISPLAY.
  - `h_sync` = HS_POL when H_DISPLAY+H_FRONT ≤ h < H_DISPLAY+H_FRONT+H_SYNC, else ~HS_POL. Default window is 656..751.
  - `v_sync` = VS_POL when V_DISPLAY+V_FRONT ≤ v < V_DISPLAY+V_FRONT+V_SYNC, else ~VS_POL. Default window is 490..491.
  - `x_loc` = h; `y_loc` = v.
- `line_start` is 1 for exactly the one clock following an edge where h wrapped to 0; 0 otherwise.
- `frame_start` is 1 for exactly the one clock following an edge where both h and v wrapped to 0. `line_start` is also 1 in that clock.
- `en`=0 freezes `div_cnt`, the counters and all outputs. Strobes drop to 0 after one clock and are not re-issued.
- Reset has priority over `en`. Reset asserted mid-frame aborts the frame immediately with no strobe.
- Reset values:
  - `div_cnt`=0, h=v=0.
  - `x_loc`=`y_loc`=0, `video_on`=1.
  - `h_sync`=~HS_POL, `v_sync`=~VS_POL.
  - `line_start`=`frame_start`=0.
  - `pix_tick`=0 while reset is high.

## Timing
- Latency: counters and decoded outputs change on the same edge, one edge after the cycle in which `pix_tick`=1.
- Each pixel lasts CLK_DIV clocks while `en`=1.
- Default line = 800 × 2 = 1600 clks. Default frame = 525 × 1600 = 840000 clks.
- First `pix_tick` after reset release falls in the CLK_DIV-th clock, given `en`=1 throughout.
- Strobe width is one clk, independent of CLK_DIV.
- No combinational path from `en` or `reset` to `h_sync`/`v_sync`/`video_on`/`x_loc`/`y_loc`.

## Test plan
- Defaults, `en`=1, release reset:
  - `pix_tick` pattern is 0,1,0,1…
  - `x_loc` increments every 2 clks.
  - After 1600 clks, `x_loc`=0 and `y_loc`=1, with `line_start` high for one clk and `frame_start` low.
- Horizontal decode, line 0:
  - `video_on` 1 at x=639, 0 at x=640.
  - `h_sync` 1 at x=655, 0 at x=656..751, 1 at x=752.
- Frame wrap:
  - Tick at (799,524) → next (0,0), with `frame_start` and `line_start` each high for one clk.
  - `v_sync`=0 only for y=490..491.
  - `frame_start` period is 840000 clks.
- Enable gating: drop `en` for 10 clks at x=100.
  - `pix_tick`=0 and `x_loc` holds 100 throughout.
  - On resume the sequence continues at 101 with unchanged spacing.
- Reset mid-frame at (300,200) with `en`=1:
  - The next clk shows `x_loc`=`y_loc`=0, `h_sync`=`v_sync`=1, `video_on`=1.
  - No `frame_start`/`line_start` pulse.
- Parameter set CLK_DIV=1, HS_POL=1, H 8/1/2/1, V 4/1/1/1:
  - `h_sync`=1 only at x=9,10.
  - `v_sync`=0 only at y=5.
  - Line is 12 clks; `frame_start` period is 84 clks.
